// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle WIDTH-bit subtractor resolving BITS_PER_CYCLE bits per clock.
// Optional signed-overflow output Ovf when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);
  localparam int B  = BITS_PER_CYCLE;
  localparam int K  = WIDTH / B;
  localparam int CW = $clog2(K + 1);
  if (WIDTH % B != 0) begin : g_bad_bpc
    $error("BITS_PER_CYCLE must divide WIDTH");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             borrow_q, borrow_d, bout_q, bout_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [B:0]       slice;
  logic [WIDTH+B-1:0] shifted;
`ifdef SERIAL_SUB_OVF_EN
  logic [1:0]       msb_q, msb_d;
  logic             ovf_q, ovf_d;
`endif
  always_comb begin
    slice       = {1'b0, a_q[B-1:0]} - {1'b0, b_q[B-1:0]} - {{B{1'b0}}, borrow_q};
    shifted     = {slice[B-1:0], res_q};
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    borrow_d    = borrow_q;
    bout_d      = bout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SERIAL_SUB_OVF_EN
    msb_d       = msb_q;
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_d        = operand1;
          b_d        = operand2;
          borrow_d   = 1'b0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
`ifdef SERIAL_SUB_OVF_EN
          msb_d      = {operand1[WIDTH-1], operand2[WIDTH-1]};
`endif
        end
      end
      BUSY: begin
        // difference slices enter at the MSB so the LSB slice lands at bit 0 after K shifts
        res_d    = shifted[WIDTH+B-1:B];
        a_d      = a_q >> B;
        b_d      = b_q >> B;
        borrow_d = slice[B];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) begin
          bout_d      = slice[B];
          out_valid_d = 1'b1;
          state_d     = DONE;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d       = (msb_q[1] ^ msb_q[0]) & (slice[B-1] ^ msb_q[1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      borrow_q    <= 1'b0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      msb_q       <= '0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      borrow_q    <= borrow_d;
      bout_q      <= bout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SERIAL_SUB_OVF_EN
      msb_q       <= msb_d;
      ovf_q       <= ovf_d;
`endif
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Result    = res_q;
  assign Bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign Ovf       = ovf_q;
`endif
endmodule
